// File: rtl/trig_mon_pkg.sv
// Shared types and default constants for the trigger event monitor.
package trig_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    PENDING = 2'd2,
    HOLD    = 2'd3
  } mon_state_t;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TS_W    = 32;
  localparam int DEF_HOLDOFF = 8;

endpackage

// File: rtl/trig_event_monitor_edge.sv
// trig_edge_det: registers the trigger level and flags its rising edge.
module trig_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

  // q tracks d in every FSM state, so a level already high on arming never looks like an edge
  assign rise = d & ~q;

endmodule

// File: rtl/trig_event_monitor.sv
// Trigger event monitor: captures AES round state on accepted trigger edges, raises irq,
// enforces a holdoff after ack. Optional timestamping via `TRIG_MON_TIMESTAMP_EN.
module trig_event_monitor
  import trig_mon_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TS_W    = DEF_TS_W,
  parameter int HOLDOFF = DEF_HOLDOFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               tj_trig,
  input  logic [127:0]       state,
  output logic               irq,
  input  logic               irq_ack,
  output logic [CNT_W-1:0]   evt_count,
  output logic [127:0]       cap_state,
  output logic [TS_W-1:0]    cap_ts,
  output logic               overflow
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF - 1);

  mon_state_t fsm;
  logic [7:0] hold_cnt;
  logic       trig_rise;
  logic       accept;

  trig_edge_det u_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (tj_trig),
    .rise (trig_rise)
  );

  assign accept = (fsm == ARMED) && en && trig_rise;

`ifdef TRIG_MON_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts     <= '0;
      cap_ts <= '0;
    end else begin
      ts <= ts + 1'b1;
      if (accept) cap_ts <= ts;
    end
  end
`else
  assign cap_ts = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      irq       <= 1'b0;
      overflow  <= 1'b0;
      evt_count <= '0;
      cap_state <= '0;
      hold_cnt  <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (en) fsm <= ARMED;
        end
        ARMED: begin
          if (!en) begin
            fsm <= IDLE;
          end else if (trig_rise) begin
            cap_state <= state;
            if (evt_count != '1) evt_count <= evt_count + 1'b1;
            irq <= 1'b1;
            fsm <= PENDING;
          end
        end
        PENDING: begin
          // an edge coinciding with ack still marks overflow; the ack is honoured too
          if (trig_rise) overflow <= 1'b1;
          if (irq_ack) begin
            irq      <= 1'b0;
            hold_cnt <= HOLD_LOAD;
            fsm      <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt == '0) fsm <= en ? ARMED : IDLE;
          else                hold_cnt <= hold_cnt - 1'b1;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trig_event_monitor.sv
// Scoreboard bench for trig_event_monitor: a cycle-counting reference model predicts accepted
// events into a queue; a negedge monitor pops and compares whenever irq rises.
module tb_trig_event_monitor;

  localparam int CNT_W   = 2;
  localparam int TS_W    = 32;
  localparam int HOLDOFF = 8;
  localparam int MAXC    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             tj_trig = 1'b0;
  logic [127:0]     state = '0;
  logic             irq;
  logic             irq_ack = 1'b0;
  logic [CNT_W-1:0] evt_count;
  logic [127:0]     cap_state;
  logic [TS_W-1:0]  cap_ts;
  logic             overflow;

  trig_event_monitor #(
    .CNT_W   (CNT_W),
    .TS_W    (TS_W),
    .HOLDOFF (HOLDOFF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .tj_trig   (tj_trig),
    .state     (state),
    .irq       (irq),
    .irq_ack   (irq_ack),
    .evt_count (evt_count),
    .cap_state (cap_state),
    .cap_ts    (cap_ts),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cnt;
    logic [127:0] st;
    logic [31:0]  ts;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: "busy" from acceptance until HOLDOFF cycles after the ack.
  bit           m_prev_trig;
  bit           m_armed, m_pending, m_hold;
  int           m_hold_left;
  int           m_events;
  bit           m_irq, m_ovf;
  logic [31:0]  m_ts;

  function automatic int exp_count();
    return (m_events > MAXC) ? MAXC : m_events;
  endfunction

  task automatic model_reset();
    m_prev_trig = 0; m_armed = 0; m_pending = 0; m_hold = 0; m_hold_left = 0;
    m_events = 0; m_irq = 0; m_ovf = 0; m_ts = 0;
    sbq.delete();
  endtask

  task automatic model_step();
    bit   rise;
    exp_t e;
    logic [31:0] ts_now;
    rise = tj_trig && !m_prev_trig;
    m_prev_trig = tj_trig;
    ts_now = m_ts;
    m_ts = m_ts + 1;
    if (m_pending) begin
      if (rise) m_ovf = 1;
      if (irq_ack) begin
        m_irq = 0; m_pending = 0; m_hold = 1; m_hold_left = HOLDOFF;
      end
    end else if (m_hold) begin
      m_hold_left--;
      if (m_hold_left == 0) begin
        m_hold = 0; m_armed = en;
      end
    end else if (m_armed) begin
      if (!en) m_armed = 0;
      else if (rise) begin
        m_events++;
        m_irq = 1; m_pending = 1; m_armed = 0;
        e.cnt = exp_count();
        e.st  = state;
`ifdef TRIG_MON_TIMESTAMP_EN
        e.ts  = ts_now;
`else
        e.ts  = 32'd0;
`endif
        sbq.push_back(e);
      end
    end else if (en) begin
      m_armed = 1;
    end
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic e, input logic t, input logic a, input logic [127:0] s);
    en = e; tj_trig = t; irq_ack = a; state = s;
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tj_trig = 1'b0; irq_ack = 1'b0;
    #1;
    chk("rst_irq", {127'd0, irq}, '0);
    chk("rst_ovf", {127'd0, overflow}, '0);
    chk("rst_cnt", 128'(evt_count), '0);
    chk("rst_cap_state", cap_state, '0);
    chk("rst_cap_ts", 128'(cap_ts), '0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  // Monitor: cycle-level flags plus scoreboard pop on every irq rising edge.
  bit prev_irq = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_irq = 0;
    end else begin
      chk("irq", {127'd0, irq}, {127'd0, m_irq});
      chk("overflow", {127'd0, overflow}, {127'd0, m_ovf});
      chk("evt_count", 128'(evt_count), 128'(exp_count()));
      if (irq && !prev_irq) begin
        if (sbq.size() == 0) begin
          chk("unexpected_event", {127'd0, irq}, '0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_count", 128'(evt_count), 128'(e.cnt));
          chk("sb_cap_state", cap_state, e.st);
          chk("sb_cap_ts", 128'(cap_ts), 128'(e.ts));
        end
      end
      prev_irq = irq;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

  localparam logic [127:0] ST_A = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] ST_B = 128'hdeadbeef_01234567_89abcdef_fedcba98;

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // single pulse captured
    cycle(1, 0, 0, '0);
    cycle(1, 1, 0, ST_A);
    chk("first_irq", {127'd0, irq}, 128'd1);
    chk("first_count", 128'(evt_count), 128'd1);
    chk("first_cap", cap_state, ST_A);
    cycle(1, 0, 0, '0);

    // second pulse while pending -> overflow, capture unchanged
    cycle(1, 1, 0, ST_B);
    cycle(1, 0, 0, '0);
    chk("ovf_set", {127'd0, overflow}, 128'd1);
    chk("ovf_cap_kept", cap_state, ST_A);
    chk("ovf_count_kept", 128'(evt_count), 128'd1);
    cycle(1, 0, 1, '0);
    chk("ack_clears", {127'd0, irq}, '0);

    // holdoff: pulse at +3 ignored, pulse at +HOLDOFF+1 accepted
    cycle(1, 0, 0, '0);
    cycle(1, 0, 0, '0);
    cycle(1, 1, 0, ST_B);
    for (int k = 4; k <= HOLDOFF; k++) cycle(1, 0, 0, '0);
    chk("holdoff_ignored", 128'(evt_count), 128'd1);
    cycle(1, 1, 0, ST_B);
    chk("holdoff_accept", 128'(evt_count), 128'd2);
    chk("holdoff_cap", cap_state, ST_B);
    cycle(1, 0, 1, '0);
    for (int k = 0; k < HOLDOFF + 2; k++) cycle(0, 0, 0, '0);

    // trigger already high when arming does not count
    cycle(0, 1, 0, ST_A);
    for (int k = 0; k < 4; k++) cycle(1, 1, 0, ST_A);
    chk("prearmed_ignored", 128'(evt_count), 128'd2);
    cycle(1, 0, 0, '0);
    cycle(1, 1, 0, ST_A);
    chk("rearm_edge", 128'(evt_count), 128'd3);

    // saturation: more acked events keep count at MAXC
    for (int n = 0; n < 3; n++) begin
      cycle(1, 0, 1, '0);
      for (int k = 0; k < HOLDOFF + 1; k++) cycle(1, 0, 0, '0);
      cycle(1, 1, 0, 128'(n + 5));
    end
    chk("saturated", 128'(evt_count), 128'(MAXC));

    // reset in PENDING clears everything asynchronously
    do_reset();

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      cycle(($urandom_range(0, 15) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0), {$urandom, $urandom, $urandom, $urandom});
    end

    cycle(0, 0, 0, '0);
    cycle(0, 0, 0, '0);
    chk("scoreboard_drained", 128'(sbq.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trig_event_monitor.md
TRIG_EVENT_MONITOR -- requirements
Module: trig_event_monitor

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the event-counter width.
REQ-002 Parameter TS_W, default 32, SHALL set the free-running timestamp width.
REQ-003 Parameter HOLDOFF, default 8, SHALL set the re-arm delay in cycles (legal range 1..255).
REQ-004 clk  input  1  SHALL be the single clock; all state is updated on its rising edge.
REQ-005 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 en  input  1  SHALL arm the monitor while 1.
REQ-007 tj_trig  input  1  SHALL carry the level trigger from the upstream trigger detector.
REQ-008 state  input  128  SHALL carry the AES round state that accompanies tj_trig.
REQ-009 irq  output  1  SHALL signal that a captured event awaits acknowledgement.
REQ-010 irq_ack  input  1  SHALL acknowledge irq.
REQ-011 evt_count  output  CNT_W  SHALL give the number of accepted events.
REQ-012 cap_state  output  128  SHALL give the state captured at the last accepted event.
REQ-013 cap_ts  output  TS_W  SHALL give the timestamp of the last accepted event (0 when TRIG_MON_TIMESTAMP_EN is off).
REQ-014 overflow  output  1  SHALL be a sticky flag for an event that arrives while irq is pending.

Function
REQ-015 FSM states SHALL be IDLE, ARMED, PENDING and HOLD.
- IDLE->ARMED when en=1.
- ARMED->IDLE when en=0.
REQ-016 The monitor SHALL register tj_trig once (trig_q); an accepted event is a rising edge: tj_trig=1 and trig_q=0 while in ARMED.
REQ-017 On an accepted event, the same edge SHALL:
- capture state into cap_state;
- capture the timestamp into cap_ts;
- increment evt_count;
- set irq;
- move the FSM to PENDING.
irq, cap_state and evt_count SHALL therefore be visible 1 cycle after the edge.
REQ-018 evt_count SHALL saturate at all-ones and SHALL NOT wrap.
REQ-019 In PENDING, irq_ack=1 SHALL clear irq on the next edge, load the holdoff counter with HOLDOFF-1 and move the FSM to HOLD.
REQ-020 In PENDING, any further tj_trig rising edge SHALL set overflow.
- cap_state, cap_ts and evt_count SHALL remain unchanged.
- If the rising edge and irq_ack occur in the same cycle, overflow SHALL still be set and the ack SHALL be honoured.
REQ-021 In HOLD, trigger edges SHALL be ignored.
- The FSM SHALL return to ARMED (en=1) or IDLE (en=0) on the cycle the holdoff counter reaches 0.
- The counter SHALL decrement by 1 per cycle.
REQ-022 irq_ack SHALL be ignored outside PENDING.
REQ-023 Dropping en in PENDING or HOLD SHALL NOT abort the sequence; the FSM SHALL go to IDLE at the end of HOLD.
REQ-024 overflow SHALL clear only on reset.
REQ-025 A trigger that is already high when ARMED is entered SHALL NOT count until it falls and rises again (trig_q tracks tj_trig in all states).

Reset
REQ-026 While rst=1, the block SHALL hold:
- FSM in IDLE;
- trig_q, irq and overflow at 0;
- evt_count, cap_state and cap_ts at 0;
- timestamp and holdoff counters at 0.
Reset asserted mid-PENDING or mid-HOLD SHALL discard the event immediately.

Configuration
REQ-027 With TRIG_MON_TIMESTAMP_EN defined, the block SHALL include a TS_W free-running counter that increments every cycle from reset and wraps; cap_ts captures its value.
REQ-028 Without TRIG_MON_TIMESTAMP_EN, the counter SHALL NOT be synthesised and cap_ts SHALL tie to 0.

Structure
REQ-029 A shared package trig_mon_pkg SHALL hold the FSM state enum (2-bit) and the default constants for CNT_W, TS_W and HOLDOFF.
REQ-030 The block SHALL contain one sub-module, trig_edge_det (register plus rising-edge pulse); the rest SHALL be flat.

Verification
REQ-031 en=1, single tj_trig pulse, state=128'h00112233_44556677_8899aabb_ccddeeff -> irq=1 next cycle, evt_count=1, cap_state equals that value.
REQ-032 PENDING with a second pulse carrying a different state -> overflow=1; cap_state and evt_count unchanged; irq_ack then clears irq.
REQ-033 irq_ack, then a pulse at 3 cycles after the ack -> ignored; a pulse at HOLDOFF+1 cycles after the ack -> accepted, evt_count=2.
REQ-034 tj_trig high before en rises -> no event; tj_trig low then high -> one event.
REQ-035 CNT_W=2 with 5 acked events -> evt_count saturates at 3.
REQ-036 rst asserted during PENDING -> all outputs 0 asynchronously; with TRIG_MON_TIMESTAMP_EN, an event 10 cycles after reset release -> cap_ts=10.
